// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph definitions (active-low, bit0 = segment a .. bit6 = segment g)
// plus encode/decode helpers used by both the encoder and the decoder.
package seg7_pkg;

  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h18;
  localparam logic [6:0] GLYPH_A     = 7'h08;
  localparam logic [6:0] GLYPH_B     = 7'h03;
  localparam logic [6:0] GLYPH_C     = 7'h46;
  localparam logic [6:0] GLYPH_D     = 7'h21;
  localparam logic [6:0] GLYPH_E     = 7'h06;
  localparam logic [6:0] GLYPH_F     = 7'h0E;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH_DASH  = 7'h3F;

  typedef struct packed {
    logic       invalid;
    logic [3:0] digit;
  } seg7_dec_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  function automatic logic [6:0] seg7_encode(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

  // Anything outside the hex table (dash included) decodes as invalid with digit 0.
  function automatic seg7_dec_t seg7_decode(input logic [6:0] g);
    seg7_dec_t res;
    res.invalid = 1'b1;
    res.digit   = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (g == seg7_encode(4'(i))) begin
        res.invalid = 1'b0;
        res.digit   = 4'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_stability_filter.sv
// Glyph stability filter: strobes accept_o once when the synchronized glyph has been
// identical for STABLE_CYCLES consecutive samples; glyph_o carries that glyph.
module seg7_stability_filter import seg7_pkg::*; #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] sync2_i,
  output logic       accept_o,
  output logic [6:0] glyph_o
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [6:0]    prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept_q, accept_d;

  always_comb begin
    cnt_d    = cnt_q;
    accept_d = 1'b0;
    if (sync2_i != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q < LAST) begin
      cnt_d    = cnt_q + CW'(1);
      accept_d = (cnt_q == LAST - CW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= GLYPH_BLANK;
      cnt_q    <= '0;
      accept_q <= 1'b0;
    end else begin
      prev_q   <= sync2_i;
      cnt_q    <= cnt_d;
      accept_q <= accept_d;
    end
  end

  // prev_q cannot change on the edge that raises accept_q, so it still holds the accepted glyph.
  assign accept_o = accept_q;
  assign glyph_o  = prev_q;

endmodule

// File: rtl/seg7_decoder.sv
// Active-low 7-segment bus decoder: synchronize, wait for a settled glyph, decode it and
// deliver each new digit through a one-deep valid/ready output register.
module seg7_decoder import seg7_pkg::*; #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_digit,
  output logic       out_invalid,
  output logic       overflow,
  input  logic       clear_ovf
);

  logic [6:0] sync1_q, sync2_q;
  logic       seg_bit7_unused;

  assign seg_bit7_unused = seg_in[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= GLYPH_BLANK;
      sync2_q <= GLYPH_BLANK;
    end else begin
      sync1_q <= seg_in[6:0];
      sync2_q <= sync1_q;
    end
  end

  logic       filt_accept;
  logic [6:0] filt_glyph;

  seg7_stability_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync2_i  (sync2_q),
    .accept_o (filt_accept),
    .glyph_o  (filt_glyph)
  );

  seg7_dec_t  dec;
  logic       is_event, drop;
  logic [6:0] last_q;
  out_state_e state_q;
  logic       valid_q, invalid_q, ovf_q;
  logic [3:0] digit_q;

  // A blank is remembered but never reported, so a digit shown again after a blank re-emits.
  assign dec      = seg7_decode(filt_glyph);
  assign is_event = filt_accept && (filt_glyph != last_q) && (filt_glyph != GLYPH_BLANK);
  assign drop     = is_event && valid_q && !out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= GLYPH_BLANK;
      state_q   <= ST_EMPTY;
      valid_q   <= 1'b0;
      digit_q   <= 4'h0;
      invalid_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (filt_accept && (filt_glyph != last_q)) last_q <= filt_glyph;

      case (state_q)
        ST_EMPTY: begin
          if (is_event) begin
            state_q   <= ST_FULL;
            valid_q   <= 1'b1;
            digit_q   <= dec.digit;
            invalid_q <= dec.invalid;
          end
        end
        ST_FULL: begin
          if (is_event && out_ready) begin
            digit_q   <= dec.digit;
            invalid_q <= dec.invalid;
          end else if (!is_event && out_ready) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          valid_q <= 1'b0;
        end
      endcase

      if (drop) begin
        ovf_q <= 1'b1;
      end else if (clear_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_digit   = digit_q;
  assign out_invalid = invalid_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seg7_decoder.sv
// Self-checking bench for seg7_decoder: directed scenarios plus random glyph streams,
// compared every cycle against a run-length / event-queue reference model.
module tb_seg7_decoder;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] seg_in = 8'h7F;
  logic       out_ready = 1'b1;
  logic       clear_ovf = 1'b0;
  logic       out_valid;
  logic [3:0] out_digit;
  logic       out_invalid;
  logic       overflow;

  seg7_decoder #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_digit   (out_digit),
    .out_invalid (out_invalid),
    .overflow    (overflow),
    .clear_ovf   (clear_ovf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit       m_valid, m_inv, m_ovf;
  bit [3:0] m_dig;
  bit [6:0] m_last, run_val;
  int       run_cnt, cyc;
  bit       pend_v [8];
  bit [4:0] pend_d [8];

  function automatic bit [6:0] ref_glyph(input int d);
    case (d)
      0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
      4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
      8: return 7'h00;   9: return 7'h18;  10: return 7'h08;  11: return 7'h03;
     12: return 7'h46;  13: return 7'h21;  14: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  function automatic bit [4:0] ref_decode(input bit [6:0] g);
    for (int d = 0; d < 16; d++) begin
      if (ref_glyph(d) == g) return {1'b0, 4'(d)};
    end
    return 5'h10;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_inv = 0; m_ovf = 0; m_dig = 0;
    m_last = 7'h7F; run_val = 7'h7F; run_cnt = 1; cyc = 0;
    for (int i = 0; i < 8; i++) begin
      pend_v[i] = 0;
      pend_d[i] = 0;
    end
  endtask

  // One clock: model consumes the inputs seen at this edge, then outputs are compared.
  task automatic step();
    bit       ev, xfer, drp;
    bit [4:0] evd;
    bit [6:0] g;
    int       sl;
    @(posedge clk);
    #1;
    cyc++;
    sl = cyc % 8;
    ev = pend_v[sl];
    evd = pend_d[sl];
    pend_v[sl] = 0;
    xfer = m_valid && out_ready;
    drp = ev && m_valid && !out_ready;
    if (xfer) $display("[TB] cycle %0d transfer digit=%h invalid=%0d", cyc, m_dig, m_inv);
    if (drp) $display("[TB] cycle %0d event dropped digit=%h invalid=%0d", cyc, evd[3:0], evd[4]);
    if (ev && !drp) begin
      m_valid = 1;
      m_inv = evd[4];
      m_dig = evd[3:0];
    end else if (xfer) begin
      m_valid = 0;
    end
    if (drp) m_ovf = 1;
    else if (clear_ovf) m_ovf = 0;

    g = seg_in[6:0];
    if (g == run_val) begin
      if (run_cnt < 1000) run_cnt++;
    end else begin
      run_val = g;
      run_cnt = 1;
    end
    // A glyph held for S samples is accepted; it reaches the output register three edges later.
    if (run_cnt == S && g != m_last) begin
      m_last = g;
      if (g != 7'h7F) begin
        pend_v[(cyc + 3) % 8] = 1;
        pend_d[(cyc + 3) % 8] = ref_decode(g);
      end
    end

    check("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      check("out_digit", 32'(out_digit), 32'(m_dig));
      check("out_invalid", 32'(out_invalid), 32'(m_inv));
    end
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic drive(input bit [7:0] v, input int n);
    seg_in = v;
    repeat (n) step();
  endtask

  initial begin
    bit       b7;
    bit [6:0] g;
    int       r, hold;

    model_reset();
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_digit", 32'(out_digit), 32'd0);
    check("rst_invalid", 32'(out_invalid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single settled digit, held
    out_ready = 1'b1;
    drive(8'h30, 20);

    // 2: glitch restarts the count
    drive(8'h12, 2);
    drive(8'h13, 2);
    drive(8'h12, 12);

    // 3: sweep all glyphs with bit7 toggling, then dash
    for (int d = 0; d < 16; d++) begin
      for (int c = 0; c < 10; c++) begin
        b7 = 1'($urandom());
        seg_in = {b7, ref_glyph(d)};
        step();
      end
    end
    drive(8'h3F, 10);

    // 4: blank separates repeats; back-to-back repeats collapse
    drive(8'h79, 8);
    drive(8'h7F, 8);
    drive(8'h79, 8);
    drive(8'h40, 8);
    drive(8'h79, 8);
    drive(8'hF9, 8);

    // 5: backpressure, drop, overflow, clear
    out_ready = 1'b0;
    drive(8'h19, 10);
    drive(8'h02, 10);
    out_ready = 1'b1;
    step();
    step();
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    step();

    // Random glyph streams with random backpressure and overflow clears
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 19);
      if (r < 16) g = ref_glyph(r);
      else if (r == 16) g = 7'h7F;
      else if (r == 17) g = 7'h3F;
      else g = 7'($urandom());
      hold = $urandom_range(1, S + 3);
      for (int c = 0; c < hold; c++) begin
        b7 = 1'($urandom());
        seg_in = {b7, g};
        out_ready = ($urandom_range(0, 9) < 7);
        clear_ovf = ($urandom_range(0, 19) == 0);
        step();
      end
    end
    clear_ovf = 1'b0;

    // 6: asynchronous reset while an event is pending and a new glyph is mid-count
    out_ready = 1'b0;
    drive(8'h7F, 8);
    drive(8'h19, 10);
    drive(8'h02, 10);
    drive(8'h24, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_overflow", 32'(overflow), 32'd0);
    check("async_digit", 32'(out_digit), 32'd0);
    check("async_invalid", 32'(out_invalid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    out_ready = 1'b1;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
